// File: rtl/proc_trace_buf_pkg.sv
// Shared definitions for the proc trace capture block: datapath widths,
// trace FSM state encoding and the packed trace entry layout.
package proc_trace_buf_pkg;

  localparam int OPCODE_WIDTH = 6;
  localparam int VALUE_WIDTH  = 16;
  localparam int MEM_WIDTH    = 8;
  localparam int TS_WIDTH     = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } trace_state_t;

  typedef struct packed {
    logic [OPCODE_WIDTH-1:0] op_code;
    logic [VALUE_WIDTH-1:0]  alu_out;
    logic [MEM_WIDTH-1:0]    dest_addr;
    logic [1:0]              dest_choice;
  } trace_entry_t;

endpackage

// File: rtl/proc_trace_buf_trace_ram.sv
// Trace storage: DEPTH x WIDTH, one synchronous write port, one
// asynchronous read port, no reset on the array.
module trace_ram #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/proc_trace_buf.sv
// Circular trace capture for proc with trigger/post-trigger freeze and
// valid/ready readout. Define PROC_TRACE_TIMESTAMP_EN to prepend a cycle stamp.
module proc_trace_buf #(
  parameter int OPCODE_WIDTH = proc_trace_buf_pkg::OPCODE_WIDTH,
  parameter int VALUE_WIDTH  = proc_trace_buf_pkg::VALUE_WIDTH,
  parameter int MEM_WIDTH    = proc_trace_buf_pkg::MEM_WIDTH,
  parameter int DEPTH        = 8,
  parameter int POST_TRIG    = 2,
`ifdef PROC_TRACE_TIMESTAMP_EN
  localparam int ENTRY_W = proc_trace_buf_pkg::TS_WIDTH + OPCODE_WIDTH + VALUE_WIDTH + MEM_WIDTH + 2
`else
  localparam int ENTRY_W = OPCODE_WIDTH + VALUE_WIDTH + MEM_WIDTH + 2
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cap_valid,
  input  logic [OPCODE_WIDTH-1:0] op_code,
  input  logic [VALUE_WIDTH-1:0]  alu_out,
  input  logic [MEM_WIDTH-1:0]    dest_addr,
  input  logic [1:0]              dest_choice,
  input  logic                    arm,
  input  logic                    abort,
  input  logic [OPCODE_WIDTH-1:0] trig_opcode,
  input  logic                    rd_ready,
  output logic                    rd_valid,
  output logic [ENTRY_W-1:0]      rd_data,
  output logic                    rd_last,
  output logic [1:0]              state,
  output logic                    overflow
);
  import proc_trace_buf_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] POST_INIT = AW'(POST_TRIG);

  trace_state_t    st;
  logic [AW-1:0]   wr_ptr, rd_ptr, post_cnt;
  logic [AW:0]     count, remaining;
  logic            wr_en, trig_hit;
  logic [AW-1:0]   wr_ptr_nx, rd_start;
  logic [AW:0]     count_nx;
  logic [ENTRY_W-1:0] wr_data;

`ifdef PROC_TRACE_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ts <= '0;
    else      ts <= ts + TS_WIDTH'(1);
  end

  assign wr_data = {ts, op_code, alu_out, dest_addr, dest_choice};
`else
  assign wr_data = {op_code, alu_out, dest_addr, dest_choice};
`endif

  // Readout start is derived from the post-write pointer/count so that the
  // window is readable on the very first DONE cycle.
  always_comb begin
    wr_en     = (st == ARMED || st == POST) && cap_valid && !abort;
    trig_hit  = (op_code == trig_opcode);
    wr_ptr_nx = wr_ptr + AW'(1);
    count_nx  = (count == FULL) ? count : count + (AW+1)'(1);
    rd_start  = wr_ptr_nx - count_nx[AW-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      post_cnt  <= '0;
      count     <= '0;
      remaining <= '0;
      overflow  <= 1'b0;
    end else if (abort) begin
      st        <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      post_cnt  <= '0;
      count     <= '0;
      remaining <= '0;
      overflow  <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          if (arm) begin
            st       <= ARMED;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
          end
        end
        ARMED, POST: begin
          if (cap_valid) begin
            wr_ptr <= wr_ptr_nx;
            count  <= count_nx;
            if (count == FULL) overflow <= 1'b1;
            if (st == ARMED) begin
              if (trig_hit) begin
                if (POST_TRIG == 0) begin
                  st        <= DONE;
                  rd_ptr    <= rd_start;
                  remaining <= count_nx;
                end else begin
                  st       <= POST;
                  post_cnt <= POST_INIT;
                end
              end
            end else begin
              post_cnt <= post_cnt - AW'(1);
              if (post_cnt == AW'(1)) begin
                st        <= DONE;
                rd_ptr    <= rd_start;
                remaining <= count_nx;
              end
            end
          end
        end
        DONE: begin
          if (rd_ready && remaining != '0) begin
            rd_ptr    <= rd_ptr + AW'(1);
            remaining <= remaining - (AW+1)'(1);
            if (remaining == (AW+1)'(1)) st <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign state    = st;
  assign rd_valid = (st == DONE) && (remaining != '0);
  assign rd_last  = rd_valid && (remaining == (AW+1)'(1));

  trace_ram #(
    .DEPTH(DEPTH),
    .WIDTH(ENTRY_W)
  ) u_trace_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wr_ptr),
    .wdata(wr_data),
    .raddr(rd_ptr),
    .rdata(rd_data)
  );

endmodule

// File: tb/tb_proc_trace_buf.sv
// Randomised and directed bench for proc_trace_buf against a queue-based
// window model; instance 0 uses POST_TRIG=2, instance 1 uses POST_TRIG=0.
module tb_proc_trace_buf;
  import proc_trace_buf_pkg::*;

  localparam int DEPTH  = 8;
  localparam int BASE_W = OPCODE_WIDTH + VALUE_WIDTH + MEM_WIDTH + 2;
`ifdef PROC_TRACE_TIMESTAMP_EN
  localparam int ENTRY_W = BASE_W + TS_WIDTH;
`else
  localparam int ENTRY_W = BASE_W;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] cv = '0, arm = '0, ab = '0, rr = '0;
  logic [OPCODE_WIDTH-1:0] op = '0, trig = 6'h3F;
  logic [VALUE_WIDTH-1:0]  alu = '0;
  logic [MEM_WIDTH-1:0]    dest = '0;
  logic [1:0]              ch = '0;
  logic [1:0] rv, rl, ovf, st0, st1;
  logic [ENTRY_W-1:0] rd0, rd1;

  always #5 clk = ~clk;

  proc_trace_buf #(.DEPTH(DEPTH), .POST_TRIG(2)) dut0 (
    .clk(clk), .rst(rst), .cap_valid(cv[0]), .op_code(op), .alu_out(alu),
    .dest_addr(dest), .dest_choice(ch), .arm(arm[0]), .abort(ab[0]),
    .trig_opcode(trig), .rd_ready(rr[0]), .rd_valid(rv[0]), .rd_data(rd0),
    .rd_last(rl[0]), .state(st0), .overflow(ovf[0]));

  proc_trace_buf #(.DEPTH(DEPTH), .POST_TRIG(0)) dut1 (
    .clk(clk), .rst(rst), .cap_valid(cv[1]), .op_code(op), .alu_out(alu),
    .dest_addr(dest), .dest_choice(ch), .arm(arm[1]), .abort(ab[1]),
    .trig_opcode(trig), .rd_ready(rr[1]), .rd_valid(rv[1]), .rd_data(rd1),
    .rd_last(rl[1]), .state(st1), .overflow(ovf[1]));

  // Reference model: entries since arm (last DEPTH kept) and a phase number.
  trace_entry_t win[$];
  trace_entry_t got[$];
  int    ms, pr, pt, sel;
  bit    m_ovf;
  int    n_checks = 0, n_fail = 0;
  string phase = "init";

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] cur_state();
    return sel ? st1 : st0;
  endfunction

  function automatic logic [ENTRY_W-1:0] cur_data();
    return sel ? rd1 : rd0;
  endfunction

  task automatic compare_outputs();
    logic [ENTRY_W-1:0] d;
    logic exp_v;
    d = cur_data();
    exp_v = (ms == 3) && (win.size() > 0);
    check_eq({phase, "_state"}, cur_state(), ms);
    check_eq({phase, "_rd_valid"}, rv[sel], exp_v);
    check_eq({phase, "_overflow"}, ovf[sel], m_ovf);
    if (exp_v) begin
      check_eq({phase, "_rd_data"}, d[BASE_W-1:0], win[0]);
      check_eq({phase, "_rd_last"}, rl[sel], win.size() == 1);
    end else begin
      check_eq({phase, "_rd_last_idle"}, rl[sel], 1'b0);
    end
  endtask

  task automatic model_edge(input logic c, input trace_entry_t e, input logic ar,
                            input logic abt, input logic r);
    if (abt) begin
      ms = 0; win.delete(); m_ovf = 0;
    end else begin
      case (ms)
        0: if (ar) begin ms = 1; win.delete(); m_ovf = 0; end
        1, 2: if (c) begin
          win.push_back(e);
          if (win.size() > DEPTH) begin void'(win.pop_front()); m_ovf = 1; end
          if (ms == 1) begin
            if (e.op_code == trig) begin
              if (pt == 0) ms = 3;
              else begin pr = pt; ms = 2; end
            end
          end else begin
            pr--;
            if (pr == 0) ms = 3;
          end
        end
        default: if (r && win.size() > 0) begin
          void'(win.pop_front());
          if (win.size() == 0) ms = 0;
        end
      endcase
    end
  endtask

  // One clock: check outputs, drive inputs, advance the model at the edge.
  task automatic step(input logic c, input logic [OPCODE_WIDTH-1:0] o,
                      input logic [VALUE_WIDTH-1:0] a, input logic ar,
                      input logic abt, input logic r);
    trace_entry_t e;
    logic [ENTRY_W-1:0] d;
    compare_outputs();
    e.op_code = o; e.alu_out = a;
    e.dest_addr = MEM_WIDTH'($urandom); e.dest_choice = 2'($urandom);
    d = cur_data();
    if (rv[sel] && r) got.push_back(trace_entry_t'(d[BASE_W-1:0]));
    cv = '0; arm = '0; ab = '0; rr = '0;
    cv[sel] = c; arm[sel] = ar; ab[sel] = abt; rr[sel] = r;
    op = e.op_code; alu = e.alu_out; dest = e.dest_addr; ch = e.dest_choice;
    @(posedge clk);
    model_edge(c, e, ar, abt, r);
    @(negedge clk);
  endtask

  task automatic cap(input logic [OPCODE_WIDTH-1:0] o, input logic [VALUE_WIDTH-1:0] a);
    step(1'b1, o, a, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && ms == 3; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check_eq({phase, "_drain_idle"}, cur_state(), 2'd0);
  endtask

  task automatic hard_reset();
    rst = 1'b0;
    #1;
    check_eq({phase, "_rst_state"}, cur_state(), 2'd0);
    check_eq({phase, "_rst_valid"}, rv[sel], 1'b0);
    check_eq({phase, "_rst_ovf"}, ovf[sel], 1'b0);
    ms = 0; win.delete(); m_ovf = 0; pr = 0;
    cv = '0; arm = '0; ab = '0; rr = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic random_run(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      logic [OPCODE_WIDTH-1:0] o;
      o = ($urandom_range(0, 5) == 0) ? trig : OPCODE_WIDTH'($urandom);
      step($urandom_range(0, 9) < 6, o, VALUE_WIDTH'($urandom),
           $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0,
           $urandom_range(0, 2) != 0);
    end
  endtask

  initial begin
    logic [7:0] basic_ops [6];
    logic [ENTRY_W-1:0] held;
    basic_ops = '{8'h01, 8'h02, 8'h03, 8'h3F, 8'h04, 8'h05};
    sel = 0; pt = 2; ms = 0; pr = 0; m_ovf = 0;
    repeat (2) @(negedge clk);
    phase = "reset";
    check_eq("reset_state0", st0, 2'd0);
    check_eq("reset_state1", st1, 2'd0);
    check_eq("reset_valid", rv, 2'b00);
    check_eq("reset_ovf", ovf, 2'b00);
    rst = 1'b1;
    @(negedge clk);

    phase = "basic";
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    foreach (basic_ops[i]) cap(OPCODE_WIDTH'(basic_ops[i]), VALUE_WIDTH'(basic_ops[i]) * 2);
    check_eq("basic_done", st0, 2'd3);
    got.delete();
    drain(12);
    check_eq("basic_count", got.size(), 6);
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      check_eq("basic_op", got[i].op_code, basic_ops[i]);
      check_eq("basic_alu", got[i].alu_out, 16'(basic_ops[i]) * 2);
    end
    check_eq("basic_ovf", ovf[0], 1'b0);

    phase = "wrap";
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) cap(OPCODE_WIDTH'(1 + i % 10), VALUE_WIDTH'(i));
    cap(6'h3F, 16'd12);
    cap(6'h07, 16'd13);
    cap(6'h08, 16'd14);
    check_eq("wrap_done", st0, 2'd3);
    check_eq("wrap_ovf", ovf[0], 1'b1);
    got.delete();
    held = rd0;
    check_eq("wrap_first_alu", held[MEM_WIDTH+2 +: VALUE_WIDTH], 16'd7);
    phase = "bp";
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    held = rd0;
    check_eq("bp_valid_held", rv[0], 1'b1);
    check_eq("bp_data_held", held[MEM_WIDTH+2 +: VALUE_WIDTH], 16'd7);
    for (int i = 0; i < 20 && ms == 3; i++) step(1'b0, '0, '0, 1'b0, 1'b0, i[0]);
    check_eq("bp_idle", st0, 2'd0);
    check_eq("bp_count", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) check_eq("bp_alu_seq", got[i].alu_out, 16'(7 + i));
    check_eq("bp_ovf_kept", ovf[0], 1'b1);

    phase = "abort";
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    cap(6'h11, 16'h1);
    cap(6'h3F, 16'h2);
    cap(6'h12, 16'h3);
    check_eq("abort_in_post", st0, 2'd2);
    step(1'b1, 6'h13, 16'h4, 1'b0, 1'b1, 1'b0);
    check_eq("abort_idle", st0, 2'd0);
    check_eq("abort_valid", rv[0], 1'b0);

    phase = "rearm";
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cap(OPCODE_WIDTH'(i + 1), VALUE_WIDTH'(16'h100 + i));
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    cap(6'h3F, 16'h200);
    cap(6'h21, 16'h201);
    cap(6'h22, 16'h202);
    got.delete();
    drain(12);
    check_eq("rearm_window_len", got.size(), 6);

    phase = "arm_abort";
    step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    check_eq("arm_abort_idle", st0, 2'd0);

    phase = "rst_armed";
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    cap(6'h01, 16'h5);
    cap(6'h02, 16'h6);
    hard_reset();

    phase = "pt0";
    sel = 1; pt = 0;
    hard_reset();
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    cap(6'h01, 16'd2);
    cap(6'h02, 16'd4);
    cap(6'h3F, 16'd126);
    check_eq("pt0_done", st1, 2'd3);
    cap(6'h09, 16'hDEAD);
    got.delete();
    drain(8);
    check_eq("pt0_count", got.size(), 3);
    if (got.size() == 3) begin
      check_eq("pt0_op0", got[0].op_code, 6'h01);
      check_eq("pt0_op1", got[1].op_code, 6'h02);
      check_eq("pt0_op2", got[2].op_code, 6'h3F);
    end

    phase = "rand1";
    trig = OPCODE_WIDTH'($urandom);
    random_run(400);
    phase = "rand0";
    sel = 0; pt = 2;
    hard_reset();
    random_run(400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/proc_trace_buf.md
Name: proc_trace_buf

Overview:
- Parametrised on-chip trace capture for the proc core, replacing waveform-only observation of op_code/alu_out/dest signals.
- Records one entry per retired instruction into a circular buffer.
- Freezes the buffer a programmable number of entries after a trigger opcode is seen.
- Streams the frozen window oldest-first over a valid/ready port. Sits beside proc, fed from its existing status outputs.

Parameters:
- OPCODE_WIDTH, 6, op_code width; shared package value.
- VALUE_WIDTH, 16, alu_out width.
- MEM_WIDTH, 8, dest_addr width.
- DEPTH, 8, buffer entries; power of two, >=4.
- POST_TRIG, 2, entries captured after the trigger entry; 0..DEPTH-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- cap_valid  in  1  proc retired an instruction this cycle; sample inputs below.
- op_code  in  OPCODE_WIDTH  retired opcode.
- alu_out  in  VALUE_WIDTH  retired result.
- dest_addr  in  MEM_WIDTH  destination address.
- dest_choice  in  2  destination space select.
- arm  in  1  pulse: start capture.
- abort  in  1  pulse: discard and return to IDLE.
- trig_opcode  in  OPCODE_WIDTH  trigger match value.
- rd_ready  in  1  consumer accepts rd_data.
- rd_valid  out  1  rd_data holds a valid entry.
- rd_data  out  ENTRY_W  {op_code, alu_out, dest_addr, dest_choice}, MSB first.
- rd_last  out  1  final entry of the window.
- state  out  2  IDLE=0, ARMED=1, POST=2, DONE=3.
- overflow  out  1  pre-trigger entries were overwritten.

Behaviour:
- Reset (rst low, async) and abort:
  - state=IDLE, rd_valid=0, rd_last=0, overflow=0, pointers/counters=0. rd_data don't-care while rd_valid=0.
  - abort has priority over every other input in every state.
- IDLE:
  - arm -> ARMED; clears wr_ptr, count, overflow.
  - cap_valid is ignored.
- ARMED:
  - Each cap_valid writes the entry at wr_ptr on that edge. wr_ptr wraps modulo DEPTH. count saturates at DEPTH.
  - A write when count==DEPTH sets overflow, which is sticky until the next arm or reset.
  - If cap_valid and op_code==trig_opcode, the entry is written and post_cnt loads POST_TRIG. Next state is POST, or DONE if POST_TRIG==0.
  - arm while not IDLE is ignored.
- POST:
  - Each cap_valid writes and decrements post_cnt.
  - The write that takes post_cnt to 0 moves to DONE on the same edge.
  - Trigger matches in POST have no further effect.
- DONE:
  - Captures stop. rd_ptr = wr_ptr - count (mod DEPTH); remaining = count.
  - rd_valid=1 from the first DONE cycle while remaining>0. rd_data = mem[rd_ptr], combinational from registered rd_ptr.
  - rd_valid && rd_ready advances rd_ptr (wrapping) and decrements remaining.
  - rd_last = rd_valid && remaining==1.
  - When rd_valid is high and rd_ready low, rd_data and rd_last hold stable.
  - The handshake on the last entry returns the block to IDLE on that edge; overflow is retained until the next arm.
- Window length = min(entries since arm, DEPTH). It always ends with the POST_TRIG entries after the trigger.
- Latency: capture to readable is 0 cycles after DONE entry. One entry per cycle readout at full throughput.

Optional Feature:
- PROC_TRACE_TIMESTAMP_EN defined:
  - A 16-bit free-running cycle counter, reset to 0, wraps at 0xFFFF.
  - The counter is stored with each entry and prepended as the MSBs of rd_data. ENTRY_W grows by 16.
- Undefined: no counter; ENTRY_W = OPCODE_WIDTH+VALUE_WIDTH+MEM_WIDTH+2.

Decomposition:
- Shared package (alongside the instructions definitions):
  - OPCODE_WIDTH, VALUE_WIDTH, MEM_WIDTH.
  - trace state enum {IDLE, ARMED, POST, DONE}.
  - trace entry packed struct.
  - TS_WIDTH=16.
- One sub-module, trace_ram:
  - DEPTH x ENTRY_W storage.
  - single write port, async read port.
  - no reset on storage.

Test Plan:
- Reset: hold rst=0 mid-stream, release -> state=0, rd_valid=0, overflow=0. Assert rst=0 during ARMED -> immediate IDLE.
- Basic (DEPTH=8, POST_TRIG=2, trig_opcode=0x3F):
  - Stimulus: arm, then captures op 1,2,3,0x3F,4,5, with alu_out = op*2.
  - Response: DONE after op 5. Reads op 1,2,3,0x3F,4,5 in order; rd_last only on op 5; IDLE after the 6th handshake; overflow=0.
- Wrap: arm, 12 non-trigger captures (alu_out 0..11), trigger (12), then 13,14 -> reads alu_out 7..14 (8 entries), overflow=1.
- Backpressure: in DONE, hold rd_ready=0 for 3 cycles -> rd_valid=1 and rd_data constant. Then toggle rd_ready every cycle -> no entry skipped or duplicated.
- Abort/ignore:
  - abort in POST -> IDLE next edge, rd_valid=0.
  - arm during ARMED -> no pointer clear.
  - arm+abort same cycle in IDLE -> stays IDLE.
- POST_TRIG=0 instance: arm, ops 1,2,0x3F -> DONE on trigger edge; reads 1,2,0x3F. A cap_valid in DONE does not alter the data.
